// File: rtl/pawn.sv
// ---------------------------------------------------------------------------
// pawn - hardware move generator for a single pawn.
//
// Software programs the board locations and the pawn ID through a small
// Avalon-MM slave, then writes register 0 to start a run. The block copies
// the 64-square input board from memory into a local array and scans it
// for the pawn. It then writes one complete successor board to the output
// area for every legal move. Moves are tried in this order: single push,
// double push, capture toward file-1, capture toward file+1. When the run
// finishes, register 0 holds the number of boards written.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   slave_*                control/status slave. Registers:
//                          0 start (write) / count (read)
//                          1 OUT_BASE, 2 PIECE (signed 8b), 3 IN_BASE
//   master_*               board memory master. Byte-per-square addressing.
//                          One read is outstanding at a time.
//                          Write data is the sign-extended square code.
// ---------------------------------------------------------------------------
module pawn #(
    parameter int MAX_MOVES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);

    typedef enum logic [2:0] {
        IDLE, READ_BOARD, FIND, GEN, WRITE_BOARD, DONE
    } state_t;

    // Result of evaluating the current candidate move.
    typedef struct packed {
        logic       ok;
        logic [5:0] tgt;
    } move_t;

    // Candidates are numbered 0..3 in the order they are tried.
    localparam logic [1:0] LAST_CAND = 2'(MAX_MOVES - 1);

    state_t            state, state_nxt;
    logic [31:0]       out_base, in_base;
    logic [7:0]        piece;
    logic [3:0]        count;
    logic [63:0][7:0]  board;
    logic [5:0]        idx;       // square index for read, scan and write
    logic [5:0]        src, tgt;
    logic [1:0]        cand;
    logic              rd_acc;    // read address accepted, waiting for data

    logic              busy, start, reg_we;
    logic              is_pawn, white;
    move_t             mv;
    logic [7:0]        wr_byte;

    logic signed [7:0] delta, tgt_s;
    logic [5:0]        tgt6, mid6;
    logic [7:0]        tsq, mid;
    logic              on_board, home, enemy;

    // Only bits [7:0] of a board word are meaningful.
    logic              unused_rd_bits;
    assign unused_rd_bits = ^master_readdata[31:8];

    // ---------------------------------------------------------------- slave
    assign busy   = (state == READ_BOARD) || (state == FIND) ||
                    (state == GEN) || (state == WRITE_BOARD);
    // An addr-0 access during a run is stalled. The result is then
    // released in DONE, once count is final.
    assign slave_waitrequest = busy && (slave_read || slave_write) &&
                               (slave_address == 4'd0);
    assign start  = !busy && slave_write && (slave_address == 4'd0);
    assign reg_we = !busy && slave_write;

    always_comb begin
        slave_readdata = 32'd0;
        case (slave_address)
            4'd0:    slave_readdata = {28'd0, count};
            4'd1:    slave_readdata = out_base;
            4'd2:    slave_readdata = {{24{piece[7]}}, piece};
            4'd3:    slave_readdata = in_base;
            default: slave_readdata = 32'd0;
        endcase
    end

    // ------------------------------------------------------ move evaluation
    assign is_pawn = (piece != 8'd0) && ($signed(piece) >= -8'sd8) &&
                     ($signed(piece) <= 8'sd8);
    assign white   = !piece[7];

    always_comb begin
        delta = 8'sd0;
        mv    = '0;
        case (cand)
            2'd0:    delta = white ? 8'sd8  : -8'sd8;
            2'd1:    delta = white ? 8'sd16 : -8'sd16;
            2'd2:    delta = white ? 8'sd7  : -8'sd9;   // file-1
            default: delta = white ? 8'sd9  : -8'sd7;   // file+1
        endcase
        // Signed target square. This catches pushes off the first or last rank.
        tgt_s    = $signed({2'b00, src}) + delta;
        on_board = (tgt_s >= 8'sd0) && (tgt_s <= 8'sd63);
        tgt6     = tgt_s[5:0];
        tsq      = board[tgt6];
        // Intermediate square of a double push. Only used from the home
        // rank, so it never leaves the board.
        mid6     = white ? (src + 6'd8) : (src - 6'd8);
        mid      = board[mid6];
        home     = white ? (src[5:3] == 3'd1) : (src[5:3] == 3'd6);
        // An enemy is a non-empty square with the opposite sign. A white
        // pawn captures negatives, a black pawn captures positives.
        enemy    = (tsq != 8'd0) && (tsq[7] == white);
        mv.tgt   = tgt6;
        case (cand)
            2'd0:    mv.ok = on_board && (tsq == 8'd0);
            2'd1:    mv.ok = home && (mid == 8'd0) && (tsq == 8'd0);
            2'd2:    mv.ok = on_board && (src[2:0] != 3'd0) && enemy;
            default: mv.ok = on_board && (src[2:0] != 3'd7) && enemy;
        endcase
    end

    // --------------------------------------------------------------- master
    // The successor is the input board with the source square cleared and
    // the target square set to the pawn.
    assign wr_byte = (idx == src) ? 8'd0 :
                     (idx == tgt) ? piece : board[idx];

    always_comb begin
        master_read      = 1'b0;
        master_write     = 1'b0;
        master_address   = 32'd0;
        master_writedata = 32'd0;
        case (state)
            READ_BOARD: begin
                master_read    = !rd_acc;
                master_address = in_base + {26'd0, idx};
            end
            WRITE_BOARD: begin
                master_write     = 1'b1;
                master_address   = out_base + {22'd0, count, 6'd0} + {26'd0, idx};
                master_writedata = {{24{wr_byte[7]}}, wr_byte};
            end
            default: ;
        endcase
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE:
                state_nxt = start ? READ_BOARD : IDLE;
            READ_BOARD:
                if (rd_acc && master_readdatavalid && (idx == 6'd63))
                    state_nxt = FIND;
            FIND:
                if (!is_pawn)                 state_nxt = DONE;
                else if (board[idx] == piece) state_nxt = GEN;
                else if (idx == 6'd63)        state_nxt = DONE;
            GEN:
                if (mv.ok)                    state_nxt = WRITE_BOARD;
                else if (cand == LAST_CAND)   state_nxt = DONE;
            WRITE_BOARD:
                if (!master_waitrequest && (idx == 6'd63))
                    state_nxt = (cand == LAST_CAND) ? DONE : GEN;
            default:
                state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            out_base <= '0;
            in_base  <= '0;
            piece    <= '0;
            count    <= '0;
            board    <= '0;
            idx      <= '0;
            src      <= '0;
            tgt      <= '0;
            cand     <= '0;
            rd_acc   <= 1'b0;
        end else begin
            state <= state_nxt;

            if (reg_we) begin
                case (slave_address)
                    4'd1:    out_base <= slave_writedata;
                    4'd2:    piece    <= slave_writedata[7:0];
                    4'd3:    in_base  <= slave_writedata;
                    default: ;
                endcase
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        count  <= '0;
                        idx    <= '0;
                        cand   <= '0;
                        rd_acc <= 1'b0;
                    end
                end
                READ_BOARD: begin
                    if (!rd_acc) begin
                        if (!master_waitrequest) rd_acc <= 1'b1;
                    end else if (master_readdatavalid) begin
                        board[idx] <= master_readdata[7:0];
                        idx        <= idx + 6'd1;    // wraps to 0 for FIND
                        rd_acc     <= 1'b0;
                    end
                end
                FIND: begin
                    if (board[idx] == piece) src <= idx;
                    else                     idx <= idx + 6'd1;
                end
                GEN: begin
                    if (mv.ok) begin
                        tgt <= mv.tgt;
                        idx <= '0;
                    end else begin
                        cand <= cand + 2'd1;
                    end
                end
                WRITE_BOARD: begin
                    if (!master_waitrequest) begin
                        idx <= idx + 6'd1;
                        if (idx == 6'd63) begin
                            count <= count + 4'd1;
                            cand  <= cand + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pawn.sv
// ---------------------------------------------------------------------------
// tb_pawn - self-checking bench for pawn.
// Behavioural memory with optional random stalls and delayed read data.
// Expected successor-board writes are queued by a rank/file reference model
// and popped as the DUT issues them.
// ---------------------------------------------------------------------------
module tb_pawn;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        slave_waitrequest;
    logic [3:0]  slave_address = '0;
    logic        slave_read = 1'b0;
    logic [31:0] slave_readdata;
    logic        slave_write = 1'b0;
    logic [31:0] slave_writedata = '0;
    logic        master_waitrequest = 1'b0;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata = '0;
    logic        master_readdatavalid = 1'b0;
    logic        master_write;
    logic [31:0] master_writedata;

    always #5 clk = ~clk;

    pawn dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .slave_waitrequest    (slave_waitrequest),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_readdata       (slave_readdata),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_write         (master_write),
        .master_writedata     (master_writedata)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    int                n_chk = 0;
    int                n_fail = 0;
    logic [7:0]        mem [bit [31:0]];
    wr_t               exp_q [$];
    logic signed [7:0] bd [64];
    bit                rnd_mode = 1'b0;
    int                wr_seen = 0;
    bit                pend = 1'b0;
    int                dly = 0;
    logic [7:0]        pend_byte = '0;

    function automatic logic [7:0] rd_mem(input bit [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    // Memory responder. All decisions are made on the falling edge, so the
    // values seen here are exactly what the DUT samples on the next rising edge.
    always @(negedge clk) begin
        logic [31:0] r;
        wr_t         e;
        if (!rst_n) begin
            pend                 = 1'b0;
            master_readdatavalid = 1'b0;
            master_waitrequest   = 1'b0;
        end else begin
            master_readdatavalid = 1'b0;
            if (pend) begin
                if (dly == 0) begin
                    r                    = $urandom;
                    master_readdata      = {r[31:8], pend_byte};
                    master_readdatavalid = 1'b1;
                    pend                 = 1'b0;
                end else begin
                    dly = dly - 1;
                end
            end
            master_waitrequest = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b0;
            if (master_read && !master_waitrequest) begin
                pend      = 1'b1;
                pend_byte = rd_mem(master_address);
                dly       = rnd_mode ? int'($urandom_range(0, 3)) : 0;
            end
            if (master_write && !master_waitrequest) begin
                wr_seen = wr_seen + 1;
                n_chk   = n_chk + 1;
                if (exp_q.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL sb_unexpected_write addr=%h data=%h", master_address, master_writedata);
                end else begin
                    e = exp_q.pop_front();
                    if (master_address !== e.a || master_writedata !== e.d) begin
                        n_fail = n_fail + 1;
                        $display("FAIL sb_write got addr=%h data=%h expected addr=%h data=%h",
                                 master_address, master_writedata, e.a, e.d);
                    end
                end
                mem[master_address] = master_writedata[7:0];
            end
        end
    end

    // ------------------------------------------------------------ bus tasks
    task automatic slave_rd(input logic [3:0] a, output logic [31:0] d, output int waits);
        @(negedge clk);
        slave_address = a;
        slave_read    = 1'b1;
        waits = -1;
        d     = '0;
        for (int i = 0; i < 5000; i++) begin
            #1;
            if (!slave_waitrequest) begin
                waits = i;
                d     = slave_readdata;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 slave_read = 1'b0;
    endtask

    task automatic slave_wr(input logic [3:0] a, input logic [31:0] d, output int waits);
        @(negedge clk);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        waits = -1;
        for (int i = 0; i < 5000; i++) begin
            #1;
            if (!slave_waitrequest) begin
                waits = i;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 slave_write = 1'b0;
    endtask

    // ------------------------------------------------------ reference model
    task automatic clear_bd();
        for (int i = 0; i < 64; i++) bd[i] = 8'sd0;
    endtask

    task automatic load_board(input logic [31:0] ib);
        for (int i = 0; i < 64; i++) mem[ib + 32'(i)] = bd[i];
    endtask

    task automatic gen_expected(input logic [31:0] ob, input logic signed [7:0] pc);
        int src, r, f, dir, home, nr, nf;
        int tg [$];
        logic signed [7:0] v;
        src = -1;
        for (int i = 0; i < 64; i++) if (src < 0 && bd[i] == pc) src = i;
        if (pc == 0 || pc > 8 || pc < -8 || src < 0) return;
        dir  = (pc > 0) ? 1 : -1;
        home = (pc > 0) ? 1 : 6;
        r    = src / 8;
        f    = src % 8;
        nr   = r + dir;
        if (nr >= 0 && nr <= 7 && bd[nr*8+f] == 0) tg.push_back(nr*8+f);
        if (r == home && bd[nr*8+f] == 0 && bd[(r+2*dir)*8+f] == 0) tg.push_back((r+2*dir)*8+f);
        for (int df = -1; df <= 1; df += 2) begin
            nf = f + df;
            if (nr >= 0 && nr <= 7 && nf >= 0 && nf <= 7) begin
                v = bd[nr*8+nf];
                if ((pc > 0 && v < 0) || (pc < 0 && v > 0)) tg.push_back(nr*8+nf);
            end
        end
        foreach (tg[k]) begin
            for (int i = 0; i < 64; i++) begin
                v = (i == src) ? 8'sd0 : (i == tg[k]) ? pc : bd[i];
                exp_q.push_back('{ob + 32'(64*k + i), {{24{v[7]}}, v}});
            end
        end
    endtask

    // One complete run: program, start, optionally poke registers while busy,
    // wait for the count and check the memory side effects.
    task automatic do_run(input logic [31:0] ib, input logic [31:0] ob,
                          input logic signed [7:0] pc, input int exp_cnt,
                          input bit poke, input string nm);
        logic [31:0] d;
        int          w;
        bit          same;
        load_board(ib);
        for (int i = 0; i < 64; i++) mem[ob + 32'(64*exp_cnt + i)] = 8'hA5;
        slave_wr(4'd1, ob, w);
        slave_wr(4'd2, {{24{pc[7]}}, pc}, w);
        slave_wr(4'd3, ib, w);
        exp_q.delete();
        gen_expected(ob, pc);
        wr_seen = 0;
        slave_wr(4'd0, 32'hFFFF_FFFF, w);
        if (poke) begin
            slave_rd(4'd1, d, w);
            n_chk++;
            if (w !== 0 || d !== ob) begin
                n_fail++;
                $display("FAIL %s busy_rd_out_base got %h waits=%0d expected %h waits=0", nm, d, w, ob);
            end
            slave_wr(4'd1, ~ob, w);
            n_chk++;
            if (w !== 0) begin
                n_fail++;
                $display("FAIL %s busy_wr_reg1 waits=%0d expected 0", nm, w);
            end
            slave_rd(4'd2, d, w);
            n_chk++;
            if (w !== 0 || d !== {{24{pc[7]}}, pc}) begin
                n_fail++;
                $display("FAIL %s busy_rd_piece got %h expected %h", nm, d, {{24{pc[7]}}, pc});
            end
        end
        slave_rd(4'd0, d, w);
        n_chk++;
        if (w <= 0) begin
            n_fail++;
            $display("FAIL %s addr0_stall waits=%0d expected >0 and no timeout", nm, w);
        end
        n_chk++;
        if (d !== 32'(exp_cnt)) begin
            n_fail++;
            $display("FAIL %s count got %0d expected %0d", nm, d, exp_cnt);
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s missing_writes got %0d left expected 0", nm, exp_q.size());
        end
        n_chk++;
        if (wr_seen != 64*exp_cnt) begin
            n_fail++;
            $display("FAIL %s write_total got %0d expected %0d", nm, wr_seen, 64*exp_cnt);
        end
        same = 1'b1;
        for (int i = 0; i < 64; i++)
            if (rd_mem(ob + 32'(64*exp_cnt + i)) !== 8'hA5) same = 1'b0;
        n_chk++;
        if (!same) begin
            n_fail++;
            $display("FAIL %s area_past_last_board modified, expected untouched", nm);
        end
        same = 1'b1;
        for (int i = 0; i < 64; i++)
            if (rd_mem(ib + 32'(i)) !== bd[i]) same = 1'b0;
        n_chk++;
        if (!same) begin
            n_fail++;
            $display("FAIL %s input_board modified, expected unchanged", nm);
        end
        if (poke) begin
            slave_rd(4'd1, d, w);
            n_chk++;
            if (d !== ob) begin
                n_fail++;
                $display("FAIL %s out_base_after got %h expected %h", nm, d, ob);
            end
        end
    endtask

    task automatic chk_sq(input string nm, input logic [31:0] a, input logic [7:0] e);
        n_chk++;
        if (rd_mem(a) !== e) begin
            n_fail++;
            $display("FAIL %s mem[%h] got %h expected %h", nm, a, rd_mem(a), e);
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        logic [31:0] d;
        int          w;
        n_chk++;
        if (master_read !== 1'b0 || master_write !== 1'b0 || master_address !== 32'd0 ||
            master_writedata !== 32'd0 || slave_waitrequest !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs rd=%b wr=%b addr=%h wd=%h swait=%b expected all 0",
                     master_read, master_write, master_address, master_writedata, slave_waitrequest);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            slave_rd(4'(a), d, w);
            n_chk++;
            if (d !== 32'd0 || w !== 0) begin
                n_fail++;
                $display("FAIL reset_reg%0d got %h waits=%0d expected 0 waits=0", a, d, w);
            end
        end
    endtask

    task automatic test_push();
        clear_bd();
        bd[10] = 8'sd3; bd[0] = 8'sd5; bd[63] = -8'sd4; bd[2] = -8'sd7;
        do_run(32'h100, 32'h1000, 8'sd3, 2, 1'b0, "push");
        chk_sq("push", 32'h1000 + 18, 8'd3);
        chk_sq("push", 32'h1000 + 10, 8'd0);
        chk_sq("push", 32'h1040 + 26, 8'd3);
    endtask

    task automatic test_blocked();
        clear_bd();
        bd[10] = 8'sd3; bd[18] = -8'sd2; bd[0] = 8'sd5;
        do_run(32'h100, 32'h2000, 8'sd3, 0, 1'b0, "blocked");
    endtask

    task automatic test_captures();
        clear_bd();
        bd[12] = 8'sd1; bd[19] = -8'sd3; bd[21] = -8'sd6; bd[28] = 8'sd7;
        do_run(32'h300, 32'h3000, 8'sd1, 3, 1'b0, "captures");
        chk_sq("captures", 32'h3000 + 20, 8'd1);
        chk_sq("captures", 32'h3040 + 19, 8'd1);
        chk_sq("captures", 32'h3080 + 21, 8'd1);
    endtask

    task automatic test_black_edge();
        clear_bd();
        bd[48] = -8'sd1; bd[41] = 8'sd2; bd[39] = 8'sd4;
        do_run(32'h400, 32'h4000, -8'sd1, 3, 1'b0, "black_edge");
        chk_sq("black_edge", 32'h4000 + 40, 8'hFF);
        chk_sq("black_edge", 32'h4040 + 32, 8'hFF);
        chk_sq("black_edge", 32'h4080 + 41, 8'hFF);
    endtask

    task automatic test_no_move();
        clear_bd();
        bd[10] = 8'sd3;
        do_run(32'h500, 32'h5000, -8'sd5, 0, 1'b0, "absent");
        clear_bd();
        bd[20] = 8'sd9;
        do_run(32'h500, 32'h5000, 8'sd9, 0, 1'b0, "not_pawn");
        clear_bd();
        bd[60] = 8'sd4; bd[59] = -8'sd2; bd[61] = -8'sd3;
        do_run(32'h500, 32'h5000, 8'sd4, 0, 1'b0, "white_last_rank");
        clear_bd();
        bd[3] = -8'sd2; bd[2] = 8'sd1;
        do_run(32'h500, 32'h5000, -8'sd2, 0, 1'b0, "black_last_rank");
    endtask

    task automatic test_wrap();
        clear_bd();
        bd[12] = 8'sd1; bd[19] = -8'sd3; bd[21] = -8'sd6; bd[28] = 8'sd7;
        do_run(32'h200, 32'hFFFF_FFC0, 8'sd1, 3, 1'b0, "addr_wrap");
        chk_sq("addr_wrap", 32'h0000_0000 + 19, 8'd1);
    endtask

    task automatic test_random_wait();
        rnd_mode = 1'b1;
        clear_bd();
        bd[10] = 8'sd3; bd[0] = 8'sd5; bd[63] = -8'sd4; bd[2] = -8'sd7;
        do_run(32'h600, 32'h6000, 8'sd3, 2, 1'b1, "random_wait");
        rnd_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int          w;
        rnd_mode = 1'b1;
        clear_bd();
        bd[10] = 8'sd3;
        load_board(32'h700);
        slave_wr(4'd1, 32'h7000, w);
        slave_wr(4'd2, 32'd3, w);
        slave_wr(4'd3, 32'h700, w);
        exp_q.delete();
        slave_wr(4'd0, 32'd0, w);
        repeat (40) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_chk++;
        if (master_read !== 1'b0 || master_write !== 1'b0 || master_address !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_strobes rd=%b wr=%b addr=%h expected 0 0 0",
                     master_read, master_write, master_address);
        end
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        rnd_mode = 1'b0;
        slave_rd(4'd3, d, w);
        n_chk++;
        if (d !== 32'd0 || w !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_in_base got %h waits=%0d expected 0 waits=0", d, w);
        end
        slave_rd(4'd0, d, w);
        n_chk++;
        if (d !== 32'd0 || w !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_idle_count got %h waits=%0d expected 0 waits=0", d, w);
        end
    endtask

    task automatic test_back_to_back();
        clear_bd();
        bd[10] = 8'sd3;
        do_run(32'h800, 32'h8000, 8'sd3, 2, 1'b0, "b2b_first");
        clear_bd();
        bd[12] = 8'sd1; bd[19] = -8'sd3; bd[21] = -8'sd6; bd[28] = 8'sd7;
        do_run(32'h800, 32'h9000, 8'sd1, 3, 1'b0, "b2b_second");
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        test_reset();
        test_push();
        test_blocked();
        test_captures();
        test_black_edge();
        test_no_move();
        test_wrap();
        test_random_wait();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
